// File: rtl/program_counter_pkg.sv
// Shared constants and helpers for the fetch-stage program counter.
// The offset helpers return byte offsets: sign-extended word offsets with the <<2 folded in.
package program_counter_pkg;

  localparam int          PC_W    = 64;
  localparam logic [63:0] PC_STEP = 64'd4;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  function automatic logic [PC_W-1:0] byte_off19(input logic [18:0] word_off);
    return {{43{word_off[18]}}, word_off, 2'b00};
  endfunction

  function automatic logic [PC_W-1:0] byte_off26(input logic [25:0] word_off);
    return {{36{word_off[25]}}, word_off, 2'b00};
  endfunction

endpackage

// File: rtl/alu.sv
// Small 64-bit combinational ALU; arithmetic wraps modulo 2^64 and no flags are produced.
module alu
  import program_counter_pkg::*;
(
  input  logic [PC_W-1:0] a_i,
  input  logic [PC_W-1:0] b_i,
  input  logic [2:0]      op_i,
  output logic [PC_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_PASS_B: result_o = b_i;
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/mux2_1_64.sv
// 64-bit two-input multiplexer: sel_i=0 selects in0_i, sel_i=1 selects in1_i.
module mux2_1_64
  import program_counter_pkg::*;
(
  input  logic            sel_i,
  input  logic [PC_W-1:0] in0_i,
  input  logic [PC_W-1:0] in1_i,
  output logic [PC_W-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/program_counter_d_ff_64.sv
// 64-bit register with synchronous active-low reset clearing it to zero.
module d_ff_64
  import program_counter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_ni,
  input  logic [PC_W-1:0] d_i,
  output logic [PC_W-1:0] q_o
);

  logic [PC_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/program_counter.sv
// Fetch-stage PC: advances by 4, or on a taken branch jumps relative to the
// previous cycle's PC (the branch instruction's own address).
module program_counter
  import program_counter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            BrTaken,
  input  logic            UncondBr,
  input  logic [18:0]     CondAddr19,
  input  logic [25:0]     BrAddr26,
  output logic [PC_W-1:0] out
);

  logic [PC_W-1:0] out_q;
  logic [PC_W-1:0] prev_q;
  logic [PC_W-1:0] off_byte;
  logic [PC_W-1:0] current;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] tgt_pc;
  logic [PC_W-1:0] out_d;

  mux2_1_64 u_off_mux (
    .sel_i (UncondBr),
    .in0_i (byte_off19(CondAddr19)),
    .in1_i (byte_off26(BrAddr26)),
    .out_o (off_byte)
  );

  // A taken branch is resolved one cycle after it was fetched, so its base is prev_q.
  mux2_1_64 u_base_mux (
    .sel_i (BrTaken),
    .in0_i (out_q),
    .in1_i (prev_q),
    .out_o (current)
  );

  alu u_seq_add (
    .a_i      (current),
    .b_i      (PC_STEP),
    .op_i     (ALU_ADD),
    .result_o (seq_pc)
  );

  alu u_tgt_add (
    .a_i      (current),
    .b_i      (off_byte),
    .op_i     (ALU_ADD),
    .result_o (tgt_pc)
  );

  mux2_1_64 u_next_mux (
    .sel_i (BrTaken),
    .in0_i (seq_pc),
    .in1_i (tgt_pc),
    .out_o (out_d)
  );

  d_ff_64 u_out_reg (
    .clk    (clk),
    .rst_ni (reset),
    .d_i    (out_d),
    .q_o    (out_q)
  );

  d_ff_64 u_prev_reg (
    .clk    (clk),
    .rst_ni (reset),
    .d_i    (out_q),
    .q_o    (prev_q)
  );

  assign out = out_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed vector table plus a randomized sweep against a reference model of the PC.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        BrTaken;
  logic        UncondBr;
  logic [18:0] CondAddr19;
  logic [25:0] BrAddr26;
  logic [63:0] out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  program_counter dut (
    .clk        (clk),
    .reset      (reset),
    .BrTaken    (BrTaken),
    .UncondBr   (UncondBr),
    .CondAddr19 (CondAddr19),
    .BrAddr26   (BrAddr26),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        br;
    logic        unc;
    logic [18:0] c19;
    logic [25:0] b26;
    logic [63:0] exp_out;
    logic [63:0] exp_prev;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(input logic rst_n, input logic br, input logic unc,
                       input logic [18:0] c19, input logic [25:0] b26);
    reset      = rst_n;
    BrTaken    = br;
    UncondBr   = unc;
    CondAddr19 = c19;
    BrAddr26   = b26;
  endtask

  logic [63:0] m_out;
  logic [63:0] m_prev;
  logic [63:0] m_base;
  logic [63:0] m_off;
  logic [63:0] m_next;

  initial begin
    //            rst  br  unc  c19        b26          out                    prev
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h0,                 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 19'h7ABCD, 26'h1234567, 64'h4,                 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 19'h00000, 26'h3FFFFFF, 64'h8,                 64'h4};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 19'h00003, 26'h2A5C3E1, 64'h10,                64'h8};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h14,                64'h10};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 19'h12345, 26'h3FFFFFF, 64'h0C,                64'h14};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 19'h00001, 26'h0000010, 64'h0,                 64'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h4,                 64'h0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h8,                 64'h4};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'hC,                 64'h8};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 19'h40000, 26'h0000155, 64'hFFFF_FFFF_FFF0_0008, 64'hC};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 19'h00001, 26'h3FFFFFF, 64'h10,                64'hFFFF_FFFF_FFF0_0008};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 19'h7FFFF, 26'h0000002, 64'hFFFF_FFFF_FFF0_0010, 64'h10};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h0,                 64'h0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 19'h00005, 26'h3FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 19'h00000, 26'h0000000, 64'h4,                 64'h0};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst_n, vecs[i].br, vecs[i].unc, vecs[i].c19, vecs[i].b26);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d_prev", i), dut.prev_q, vecs[i].exp_prev);
      $display("vec %0d: rst=%0b br=%0b unc=%0b out=0x%016h", i, vecs[i].rst_n,
               vecs[i].br, vecs[i].unc, out);
    end

    // Unselected offset must not matter: same conditional branch, different BrAddr26.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 19'h00003, (k == 0) ? 26'h0000000 : 26'h3FFFFFF);
      @(posedge clk); #1;
      check($sformatf("dontcare_b26_%0d", k), out, 64'h10);
      $display("dontcare run %0d: out=0x%016h", k, out);
    end

    // Randomized sweep against the reference model.
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    m_out  = 64'h0;
    m_prev = 64'h0;
    for (int combo = 0; combo < 4; combo++) begin
      for (int c = 0; c < 50; c++) begin
        drive(1'b1, combo[1], combo[0], 19'($urandom), 26'($urandom));
        m_base = BrTaken ? m_prev : m_out;
        m_off  = UncondBr ? {{38{BrAddr26[25]}}, BrAddr26} : {{45{CondAddr19[18]}}, CondAddr19};
        m_next = BrTaken ? (m_base + (m_off << 2)) : (m_base + 64'd4);
        @(posedge clk); #1;
        m_prev = m_out;
        m_out  = m_next;
        check($sformatf("sweep_%0d_%0d", combo, c), out, m_out);
        $display("sweep br=%0b unc=%0b c19=0x%05h b26=0x%07h out=0x%016h", BrTaken,
                 UncondBr, CondAddr19, BrAddr26, out);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
